integral_window_controller: RTL and testbench

//  Sequences a raster pixel stream into the integral-image line-buffer memory
//  (drives its pixel/wen) and tracks frame position. Each time the memory holds
//  a complete INTEGRAL_WIDTH x INTEGRAL_HEIGHT window, it presents the window

---
 rtl/face_detect_pkg.sv | 18 +
 rtl/raster_pos_counter.sv | 55 +++++
 rtl/integral_window_controller.sv | 179 +++++++++++++++++
 tb/tb_integral_window_controller.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/face_detect_pkg.sv
// Shared constants and FSM encoding for the face-detect front end.
// Default widths and window size used by the window controller and its counter.
package face_detect_pkg;

  localparam int unsigned DATA_WIDTH_8_DEF    = 8;
  localparam int unsigned DATA_WIDTH_16_DEF   = 16;
  localparam int unsigned INTEGRAL_WIDTH_DEF  = 3;
  localparam int unsigned INTEGRAL_HEIGHT_DEF = 3;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StStream  = 3'd1,
    StWaitMem = 3'd2,
    StPresent = 3'd3,
    StDone    = 3'd4
  } ctrl_state_e;

endpackage

// File: rtl/raster_pos_counter.sv
// Raster x/y position counter: advances on en_i, wraps x at width-1 and y at height-1.
// eof_o flags the last pixel position of the frame.
module raster_pos_counter
  import face_detect_pkg::*;
#(
  parameter int unsigned Width = DATA_WIDTH_16_DEF
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             clear_i,
  input  logic             en_i,
  input  logic [Width-1:0] width_i,
  input  logic [Width-1:0] height_i,
  output logic [Width-1:0] x_o,
  output logic [Width-1:0] y_o,
  output logic             eof_o
);

  logic [Width-1:0] x_q, x_d;
  logic [Width-1:0] y_q, y_d;
  logic             eol;

  assign eol   = (x_q == width_i - Width'(1));
  assign eof_o = eol && (y_q == height_i - Width'(1));

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (clear_i) begin
      x_d = '0;
      y_d = '0;
    end else if (en_i) begin
      if (eol) begin
        x_d = '0;
        y_d = eof_o ? '0 : y_q + Width'(1);
      end else begin
        x_d = x_q + Width'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

  assign x_o = x_q;
  assign y_o = y_q;

endmodule

// File: rtl/integral_window_controller.sv
// Feeds a raster pixel stream into the integral-image line buffer and hands each complete
// window position to the classifier, stalling the source until the classifier accepts it.
module integral_window_controller
  import face_detect_pkg::*;
#(
  parameter int unsigned DATA_WIDTH_8    = DATA_WIDTH_8_DEF,
  parameter int unsigned DATA_WIDTH_16   = DATA_WIDTH_16_DEF,
  parameter int unsigned INTEGRAL_WIDTH  = INTEGRAL_WIDTH_DEF,
  parameter int unsigned INTEGRAL_HEIGHT = INTEGRAL_HEIGHT_DEF,
  parameter int unsigned MEM_LATENCY     = 1
) (
  input  logic                     clk_os,
  input  logic                     reset_os,
  input  logic                     start,
  input  logic [DATA_WIDTH_16-1:0] frame_width,
  input  logic [DATA_WIDTH_16-1:0] frame_height,
  input  logic [DATA_WIDTH_8-1:0]  pixel_in,
  input  logic                     pixel_valid,
  output logic                     pixel_ready,
  output logic [DATA_WIDTH_8-1:0]  o_pixel,
  output logic                     o_wen,
  output logic                     o_window_valid,
  output logic [DATA_WIDTH_16-1:0] o_window_x,
  output logic [DATA_WIDTH_16-1:0] o_window_y,
  input  logic                     cls_ready,
  output logic                     o_frame_done,
  output logic                     o_busy,
  output logic                     o_error
);

  localparam int unsigned LatW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

  typedef logic [DATA_WIDTH_16-1:0] coord_t;

  ctrl_state_e             state_q, state_d;
  coord_t                  width_q, width_d;
  coord_t                  height_q, height_d;
  coord_t                  win_x_q, win_x_d;
  coord_t                  win_y_q, win_y_d;
  logic                    last_win_q, last_win_d;
  logic [LatW-1:0]         lat_q, lat_d;
  logic [DATA_WIDTH_8-1:0] pixel_q, pixel_d;
  logic                    wen_q, wen_d;
  logic                    ready_q, ready_d;
  logic                    valid_q, valid_d;
  logic                    done_q, done_d;
  logic                    busy_q, busy_d;
  logic                    error_q, error_d;

  logic   transfer;
  logic   dims_ok;
  logic   start_ok;
  logic   win_hit;
  logic   pos_eof;
  coord_t pos_x;
  coord_t pos_y;

  assign transfer = pixel_valid && ready_q;
  assign dims_ok  = (frame_width >= coord_t'(INTEGRAL_WIDTH)) &&
                    (frame_height >= coord_t'(INTEGRAL_HEIGHT));
  assign start_ok = start && (state_q == StIdle) && dims_ok;
  // Position outputs describe the pixel being accepted this cycle.
  assign win_hit  = (pos_x >= coord_t'(INTEGRAL_WIDTH - 1)) &&
                    (pos_y >= coord_t'(INTEGRAL_HEIGHT - 1));

  raster_pos_counter #(
    .Width (DATA_WIDTH_16)
  ) u_pos (
    .clk_i    (clk_os),
    .reset_i  (reset_os),
    .clear_i  (start_ok),
    .en_i     (transfer),
    .width_i  (width_q),
    .height_i (height_q),
    .x_o      (pos_x),
    .y_o      (pos_y),
    .eof_o    (pos_eof)
  );

  always_comb begin
    state_d    = state_q;
    width_d    = width_q;
    height_d   = height_q;
    win_x_d    = win_x_q;
    win_y_d    = win_y_q;
    last_win_d = last_win_q;
    lat_d      = lat_q;
    pixel_d    = transfer ? pixel_in : pixel_q;
    wen_d      = transfer;
    error_d    = start && ((state_q != StIdle) || !dims_ok);

    unique case (state_q)
      StIdle: begin
        if (start_ok) begin
          width_d  = frame_width;
          height_d = frame_height;
          state_d  = StStream;
        end
      end
      StStream: begin
        if (transfer && win_hit) begin
          win_x_d    = pos_x;
          win_y_d    = pos_y;
          last_win_d = pos_eof;
          lat_d      = LatW'(MEM_LATENCY - 1);
          state_d    = StWaitMem;
        end
      end
      StWaitMem: begin
        if (lat_q == '0) begin
          state_d = StPresent;
        end else begin
          lat_d = lat_q - LatW'(1);
        end
      end
      StPresent: begin
        if (cls_ready) begin
          state_d = last_win_q ? StDone : StStream;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    ready_d = (state_d == StStream);
    valid_d = (state_d == StPresent);
    done_d  = (state_d == StDone);
    busy_d  = (state_d != StIdle);
  end

  always_ff @(posedge clk_os) begin
    if (reset_os) begin
      state_q    <= StIdle;
      width_q    <= '0;
      height_q   <= '0;
      win_x_q    <= '0;
      win_y_q    <= '0;
      last_win_q <= 1'b0;
      lat_q      <= '0;
      pixel_q    <= '0;
      wen_q      <= 1'b0;
      ready_q    <= 1'b0;
      valid_q    <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      width_q    <= width_d;
      height_q   <= height_d;
      win_x_q    <= win_x_d;
      win_y_q    <= win_y_d;
      last_win_q <= last_win_d;
      lat_q      <= lat_d;
      pixel_q    <= pixel_d;
      wen_q      <= wen_d;
      ready_q    <= ready_d;
      valid_q    <= valid_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
      error_q    <= error_d;
    end
  end

  assign pixel_ready    = ready_q;
  assign o_pixel        = pixel_q;
  assign o_wen          = wen_q;
  assign o_window_valid = valid_q;
  assign o_window_x     = win_x_q;
  assign o_window_y     = win_y_q;
  assign o_frame_done   = done_q;
  assign o_busy         = busy_q;
  assign o_error        = error_q;

endmodule

// File: tb/tb_integral_window_controller.sv
// Scoreboard bench for integral_window_controller: random pixel frames, stalls, bad starts,
// mid-frame reset, plus a second instance with a 3-cycle memory latency.
module tb_integral_window_controller;

  localparam int unsigned IW = 3;
  localparam int unsigned IH = 3;

  logic        clk_os = 1'b0;
  logic        reset_os;
  logic        start;
  logic [15:0] frame_width;
  logic [15:0] frame_height;
  logic [7:0]  pixel_in;
  logic        pixel_valid;
  logic        cls_ready;

  logic        pixel_ready, o_wen, o_window_valid, o_frame_done, o_busy, o_error;
  logic [7:0]  o_pixel;
  logic [15:0] o_window_x, o_window_y;

  logic        pixel_ready_l3, o_wen_l3, o_window_valid_l3, o_frame_done_l3, o_busy_l3;
  logic        o_error_l3;
  logic [7:0]  o_pixel_l3;
  logic [15:0] o_window_x_l3, o_window_y_l3;

  always #5 clk_os = ~clk_os;

  integral_window_controller #(
    .MEM_LATENCY (1)
  ) dut (
    .clk_os         (clk_os),
    .reset_os       (reset_os),
    .start          (start),
    .frame_width    (frame_width),
    .frame_height   (frame_height),
    .pixel_in       (pixel_in),
    .pixel_valid    (pixel_valid),
    .pixel_ready    (pixel_ready),
    .o_pixel        (o_pixel),
    .o_wen          (o_wen),
    .o_window_valid (o_window_valid),
    .o_window_x     (o_window_x),
    .o_window_y     (o_window_y),
    .cls_ready      (cls_ready),
    .o_frame_done   (o_frame_done),
    .o_busy         (o_busy),
    .o_error        (o_error)
  );

  integral_window_controller #(
    .MEM_LATENCY (3)
  ) dut_l3 (
    .clk_os         (clk_os),
    .reset_os       (reset_os),
    .start          (start),
    .frame_width    (frame_width),
    .frame_height   (frame_height),
    .pixel_in       (8'hA5),
    .pixel_valid    (1'b1),
    .pixel_ready    (pixel_ready_l3),
    .o_pixel        (o_pixel_l3),
    .o_wen          (o_wen_l3),
    .o_window_valid (o_window_valid_l3),
    .o_window_x     (o_window_x_l3),
    .o_window_y     (o_window_y_l3),
    .cls_ready      (1'b1),
    .o_frame_done   (o_frame_done_l3),
    .o_busy         (o_busy_l3),
    .o_error        (o_error_l3)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge clk_os) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard queues, filled by the stimulus side from the reference model.
  logic [7:0]  exp_pix_q[$];
  logic [31:0] exp_win_q[$];
  int          exp_done_q[$];

  int          win_seen = 0, wen_seen = 0, done_seen = 0, wins3 = 0, last_wen3 = 0;
  bit          prev_xfer = 0, prev_valid = 0, prev_hs = 0, prev_valid3 = 0;
  logic [15:0] prev_wx = '0, prev_wy = '0;

  initial forever begin
    logic [31:0] w;
    @(negedge clk_os);
    if (reset_os) begin
      prev_xfer   = 0;
      prev_valid  = 0;
      prev_hs     = 0;
      prev_valid3 = 0;
    end else begin
      if (o_wen || prev_xfer) chk("wen_vs_transfer", o_wen, prev_xfer);
      if (o_wen) begin
        wen_seen++;
        if (exp_pix_q.size() == 0) chk("pixel_unexpected", 1, 0);
        else chk("pixel_data", o_pixel, exp_pix_q.pop_front());
      end
      if (o_window_valid) chk("ready_in_present", pixel_ready, 0);
      if (prev_valid && !prev_hs) begin
        chk("valid_hold", o_window_valid, 1);
        chk("x_hold", o_window_x, prev_wx);
        chk("y_hold", o_window_y, prev_wy);
        chk("no_wen_in_stall", o_wen, 0);
      end
      if (o_window_valid && cls_ready) begin
        win_seen++;
        if (exp_win_q.size() == 0) chk("window_unexpected", 1, 0);
        else begin
          w = exp_win_q.pop_front();
          chk("win_x", o_window_x, w[31:16]);
          chk("win_y", o_window_y, w[15:0]);
        end
      end
      if (o_frame_done) begin
        done_seen++;
        chk("windows_left_at_done", exp_win_q.size(), 0);
        chk("pixels_left_at_done", exp_pix_q.size(), 0);
        if (exp_done_q.size() == 0) chk("done_unexpected", 1, 0);
        else void'(exp_done_q.pop_front());
      end
      if (o_wen_l3) last_wen3 = cyc;
      if (o_window_valid_l3 && !prev_valid3) begin
        wins3++;
        chk("l3_valid_after_wen", cyc - last_wen3, 3);
      end
      prev_xfer   = pixel_valid && pixel_ready;
      prev_valid  = o_window_valid;
      prev_hs     = o_window_valid && cls_ready;
      prev_wx     = o_window_x;
      prev_wy     = o_window_y;
      prev_valid3 = o_window_valid_l3;
    end
  end

  task automatic chk_idle(input string tag);
    chk({tag, "_ready"}, pixel_ready, 0);
    chk({tag, "_pixel"}, o_pixel, 0);
    chk({tag, "_wen"}, o_wen, 0);
    chk({tag, "_valid"}, o_window_valid, 0);
    chk({tag, "_wx"}, o_window_x, 0);
    chk({tag, "_wy"}, o_window_y, 0);
    chk({tag, "_done"}, o_frame_done, 0);
    chk({tag, "_busy"}, o_busy, 0);
    chk({tag, "_error"}, o_error, 0);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((o_busy || o_busy_l3) && n < 2000) begin
      @(posedge clk_os);
      #1;
      n++;
    end
    if (n >= 2000) chk("idle_timeout", 1, 0);
  endtask

  task automatic run_frame(input int w, input int h, input bit bursty, input int hold_x,
                           input int hold_y, input int hold_n, input bit mid_start,
                           input bit abort);
    logic [7:0] pix[$];
    int idx   = 0;
    int held  = 0;
    int t     = 0;
    int done0 = done_seen;
    int win0  = win_seen;
    int wen0  = wen_seen;
    wait_idle();
    for (int i = 0; i < w * h; i++) begin
      pix.push_back(8'($urandom));
      exp_pix_q.push_back(pix[i]);
    end
    for (int y = IH - 1; y < h; y++)
      for (int x = IW - 1; x < w; x++) exp_win_q.push_back({16'(x), 16'(y)});
    exp_done_q.push_back(1);
    start        = 1'b1;
    frame_width  = 16'(w);
    frame_height = 16'(h);
    pixel_valid  = 1'b0;
    cls_ready    = 1'b1;
    @(posedge clk_os);
    #1;
    start = 1'b0;
    chk("busy_after_start", o_busy, 1);
    chk("no_error_good_start", o_error, 0);
    while (1) begin
      if (prev_xfer) idx++;
      if (done_seen != done0) break;
      if (t >= 4000) begin
        chk("frame_timeout", 1, 0);
        break;
      end
      if (abort && o_window_valid) begin
        cls_ready   = 1'b0;
        pixel_valid = 1'b0;
        reset_os    = 1'b1;
        @(posedge clk_os);
        #1;
        chk_idle("after_reset");
        reset_os = 1'b0;
        exp_pix_q.delete();
        exp_win_q.delete();
        exp_done_q.delete();
        return;
      end
      if (mid_start && t == 16) begin
        chk("mid_start_error", o_error, 1);
        chk("mid_start_busy", o_busy, 1);
      end
      start       = mid_start && (t == 15);
      frame_width = (mid_start && t == 15) ? 16'd7 : 16'(w);
      pixel_valid = (idx < w * h) && (!bursty || $urandom_range(0, 1) == 1);
      pixel_in    = (idx < w * h) ? pix[idx] : 8'h00;
      cls_ready   = bursty ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (o_window_valid && o_window_x == 16'(hold_x) && o_window_y == 16'(hold_y)
          && held < hold_n) begin
        cls_ready = 1'b0;
        held++;
      end
      @(posedge clk_os);
      #1;
      t++;
    end
    pixel_valid = 1'b0;
    start       = 1'b0;
    repeat (3) @(posedge clk_os);
    #1;
    chk("frame_done_pulses", done_seen - done0, 1);
    chk("window_count", win_seen - win0, (w - IW + 1) * (h - IH + 1));
    chk("wen_count", wen_seen - wen0, w * h);
    chk("idle_after_frame", o_busy, 0);
    if (hold_n > 0) chk("stall_cycles", held, hold_n);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    reset_os     = 1'b1;
    start        = 1'b0;
    frame_width  = '0;
    frame_height = '0;
    pixel_in     = '0;
    pixel_valid  = 1'b0;
    cls_ready    = 1'b0;
    repeat (3) @(posedge clk_os);
    #1;
    chk_idle("reset");
    chk("reset_busy_l3", o_busy_l3, 0);
    reset_os = 1'b0;
    @(posedge clk_os);
    #1;

    run_frame(5, 4, 0, -1, -1, 0, 0, 0);
    run_frame(5, 4, 0, 3, 2, 10, 0, 0);

    wait_idle();
    for (int k = 0; k < 2; k++) begin
      start        = 1'b1;
      frame_width  = (k == 0) ? 16'd2 : 16'd6;
      frame_height = (k == 0) ? 16'd4 : 16'd2;
      @(posedge clk_os);
      #1;
      start = 1'b0;
      chk("undersized_error", o_error, 1);
      chk("undersized_busy", o_busy, 0);
      @(posedge clk_os);
      #1;
      chk("error_one_cycle", o_error, 0);
      chk("undersized_still_idle", o_busy, 0);
    end
    run_frame(5, 4, 0, -1, -1, 0, 1, 0);

    run_frame(8, 6, 1, -1, -1, 0, 0, 0);

    run_frame(5, 4, 0, -1, -1, 0, 0, 1);
    run_frame(5, 4, 0, -1, -1, 0, 0, 0);

    wait_idle();
    chk("l3_windows_seen", wins3 >= 6, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
